inst_fetch: RTL

Multi-cycle instruction fetch stage for the 16-bit CPU. It sits directly upstream of the opcode decoder.
- Holds the PC and issues instruction reads to the shared memory port.
- Captures the returned word into an instruction register and presents instr[15:11] as the opcode to the decoder.
- On each executed instruction, advances PC by 2 or redirects it to a branch target.

---
 rtl/inst_fetch_pkg.sv | 15 +
 rtl/inst_fetch.sv | 115 +++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 11;
  localparam int INSTR_BYTES = 2;

endpackage

// File: rtl/inst_fetch.sv
// Multi-cycle fetch: IDLE -> ISSUE -> WAIT x MEM_LAT -> VALID -> ISSUE ...
// Optional macro FETCH_ALIGN_CHECK_EN builds the sticky misaligned-branch flag.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic [DATA_W-1:0] instr,
  output logic [4:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              align_err
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        cnt_inc;
  logic              instr_valid_q, instr_valid_d;
  logic              redirect;

  assign cnt_inc  = {1'b0, cnt_q} + 4'd1;
  assign redirect = (state_q == VALID) && !stall && br_taken;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = ISSUE;
      ISSUE: begin
        if (!stall) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc[2:0];
        if (cnt_inc == 4'(MEM_LAT)) begin
          instr_d = mem_rddata;
          state_d = VALID;
        end
      end
      VALID: begin
        // A stalled VALID holds everything, including a pending branch.
        if (!stall) begin
          pc_d    = br_taken ? (br_target & ALIGN_MASK) : (pc_q + PC_STEP);
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    instr_valid_d = (state_d == VALID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      cnt_q         <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      cnt_q         <= cnt_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;

  always_comb begin
    align_err_d = align_err_q | (redirect && br_target[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) align_err_q <= 1'b0;
    else       align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  // The read strobe must drop in the same cycle the port is lent away.
  assign mem_rd      = (state_q == ISSUE) && !stall;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_q;
  assign pc_plus2    = pc_q + PC_STEP;

endmodule
